// File: rtl/dyt_writeback_arbiter_if.sv
// rtl/dyt_writeback_arbiter_if.sv - writeback arbiter bus: ALU/load results, issue, decode probes, regfile write port
interface dyt_writeback_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_busy;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [3:0]    ld_count;
  logic          err;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_valid, iss_rd, rs1_addr, rs2_addr,
    output ld_ready, iss_busy, rs1_busy, rs2_busy,
    output w_en, w_addr, w_data, ld_count, err
  );

  // Pipeline / environment side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  ld_ready, iss_busy, rs1_busy, rs2_busy,
    input  w_en, w_addr, w_data, ld_count, err
  );
endinterface

// File: rtl/dyt_writeback_arbiter.sv
// rtl/dyt_writeback_arbiter.sv - ALU/load writeback merge with load FIFO and pending-load scoreboard; DYT_WB_BYPASS_EN enables empty-FIFO load bypass
module dyt_writeback_arbiter #(
  parameter int LD_DEPTH = 2,
  parameter int AW       = 4,
  parameter int DW       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  dyt_writeback_arbiter_if.slave  bus
);
  localparam int NREG = 1 << AW;
  localparam int PW   = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW   = $clog2(LD_DEPTH) + 1;

  logic [AW+DW-1:0] mem [LD_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic             push, push_fifo, pop, bypass;

  logic             sel_valid, sel_ld;
  logic [AW-1:0]    sel_rd;
  logic [DW-1:0]    sel_data;

  logic             w_en_q, w_src_ld;
  logic [AW-1:0]    w_addr_q;
  logic [DW-1:0]    w_data_q;

  logic [NREG-1:0]  pend, pend_set, pend_clr;
  logic             err_q, err_hit;

  assign full  = (count == CW'(LD_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    push = bus.ld_valid & ~full;
`ifdef DYT_WB_BYPASS_EN
    bypass = push & empty & ~bus.alu_valid;
`else
    bypass = 1'b0;
`endif
    push_fifo = push & ~bypass;
    pop       = ~bus.alu_valid & ~empty;

    // ALU never stalls, so it always wins; the FIFO head waits
    sel_valid = 1'b0;
    sel_ld    = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_ld    = 1'b1;
      {sel_rd, sel_data} = mem[rd_ptr];
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_ld    = 1'b1;
      sel_rd    = bus.ld_rd;
      sel_data  = bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fifo) mem[wr_ptr] <= {bus.ld_rd, bus.ld_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fifo) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({push_fifo, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Destination x0 consumes the source but never writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_q   <= 1'b0;
      w_src_ld <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q   <= sel_valid & (sel_rd != '0);
      w_src_ld <= sel_ld;
      if (sel_valid && sel_rd != '0) begin
        w_addr_q <= sel_rd;
        w_data_q <= sel_data;
      end
    end
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (bus.iss_valid)       pend_set[bus.iss_rd] = 1'b1;
    if (w_en_q && w_src_ld)  pend_clr[w_addr_q]   = 1'b1;
    pend_set[0] = 1'b0;
  end

  // A fresh issue overrides a same-edge writeback clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_set;
  end

  assign err_hit = (bus.iss_valid & pend[bus.iss_rd])
                 | (w_en_q &  w_src_ld & ~pend[w_addr_q])
                 | (w_en_q & ~w_src_ld &  pend[w_addr_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign bus.ld_ready = ~full;
  assign bus.ld_count = 4'(count);
  assign bus.iss_busy = pend[bus.iss_rd];
  assign bus.rs1_busy = pend[bus.rs1_addr];
  assign bus.rs2_busy = pend[bus.rs2_addr];
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_dyt_writeback_arbiter.sv
// tb/tb_dyt_writeback_arbiter.sv - randomized and directed bench with queue-based writeback reference model
module tb_dyt_writeback_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  dyt_writeback_arbiter_if #(.AW(4), .DW(32)) bus ();

  dyt_writeback_arbiter #(.LD_DEPTH(DEPTH), .AW(4), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [35:0] m_q [$];
  bit          m_pend [16];
  bit          m_err;
  bit          m_wen, m_wld;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_err = 0; m_wen = 0; m_wld = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid = 0;  bus.ld_rd = '0;  bus.ld_data = '0;
    bus.iss_valid = 0; bus.iss_rd = '0;
  endtask

  // Reference: one clock edge of the writeback stage, from the behavioural rules
  task automatic model_step();
    logic [35:0] head;
    bit          s_en, s_ld, push, byp;
    logic [3:0]  s_rd;
    logic [31:0] s_d;
    push = bus.ld_valid && (m_q.size() < DEPTH);
    byp  = 0;
`ifdef DYT_WB_BYPASS_EN
    byp  = push && (m_q.size() == 0) && !bus.alu_valid;
`endif
    s_en = 0; s_ld = 0; s_rd = '0; s_d = '0;
    if (bus.alu_valid) begin
      s_en = 1; s_rd = bus.alu_rd; s_d = bus.alu_data;
    end else if (m_q.size() > 0) begin
      head = m_q.pop_front();
      s_en = 1; s_ld = 1; s_rd = head[35:32]; s_d = head[31:0];
    end else if (byp) begin
      s_en = 1; s_ld = 1; s_rd = bus.ld_rd; s_d = bus.ld_data;
    end
    if (push && !byp) m_q.push_back({bus.ld_rd, bus.ld_data});
    if (bus.iss_valid && m_pend[bus.iss_rd])      m_err = 1;
    if (m_wen && m_wld && !m_pend[m_waddr])       m_err = 1;
    if (m_wen && !m_wld && m_pend[m_waddr])       m_err = 1;
    if (m_wen && m_wld)                           m_pend[m_waddr] = 0;
    if (bus.iss_valid && bus.iss_rd != 0)         m_pend[bus.iss_rd] = 1;
    m_wen = s_en && (s_rd != 0);
    m_wld = s_ld;
    if (m_wen) begin
      m_waddr = s_rd;
      m_wdata = s_d;
    end
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge
  task automatic cyc();
    #1;
    check("w_en",     bus.w_en,     m_wen);
    check("w_addr",   bus.w_addr,   m_waddr);
    check("w_data",   bus.w_data,   m_wdata);
    check("ld_ready", bus.ld_ready, m_q.size() < DEPTH);
    check("ld_count", bus.ld_count, m_q.size());
    check("iss_busy", bus.iss_busy, m_pend[bus.iss_rd]);
    check("rs1_busy", bus.rs1_busy, m_pend[bus.rs1_addr]);
    check("rs2_busy", bus.rs2_busy, m_pend[bus.rs2_addr]);
    check("err",      bus.err,      m_err);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic issue(input logic [3:0] rd);
    idle(); bus.iss_valid = 1; bus.iss_rd = rd; cyc(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    int out_q [$];
    idle();
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_w_en",     bus.w_en,     0);
    check("rst_w_addr",   bus.w_addr,   0);
    check("rst_w_data",   bus.w_data,   0);
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_ld_count", bus.ld_count, 0);
    check("rst_err",      bus.err,      0);
    check("rst_rs1_busy", bus.rs1_busy, 0);
    model_reset();
    rst = 0;
    @(negedge clk);

    // ALU only: N -> N+1, and x0 suppressed
    bus.alu_valid = 1; bus.alu_rd = 4'd3; bus.alu_data = 32'hDEADBEEF;
    cyc(); idle();
    check("alu_w_en", bus.w_en, 1);
    check("alu_w_addr", bus.w_addr, 3);
    check("alu_w_data", bus.w_data, 32'hDEADBEEF);
    bus.alu_valid = 1; bus.alu_rd = 4'd0; bus.alu_data = 32'h1234;
    cyc(); idle();
    check("alu_x0_w_en", bus.w_en, 0);
    cyc();

    // Contention: load x7 waits behind three ALU writes to x2
    bus.rs1_addr = 4'd7;
    issue(4'd7);
    bus.alu_valid = 1; bus.alu_rd = 4'd2; bus.alu_data = 32'h22;
    bus.ld_valid = 1; bus.ld_rd = 4'd7; bus.ld_data = 32'h55;
    cyc();
    bus.ld_valid = 0;
    cyc(); cyc();
    idle();
    cyc();
    check("cont_w_addr", bus.w_addr, 7);
    check("cont_w_data", bus.w_data, 32'h55);
    check("cont_rs1_busy_before", bus.rs1_busy, 1);
    cyc();
    check("cont_rs1_busy_after", bus.rs1_busy, 0);
    cyc();

    // FIFO full under a continuous ALU stream
    issue(4'd10); issue(4'd11); issue(4'd12);
    bus.alu_valid = 1; bus.alu_rd = 4'd2;
    bus.ld_valid = 1; bus.ld_rd = 4'd10; bus.ld_data = 32'hA10; cyc();
    bus.ld_rd = 4'd11; bus.ld_data = 32'hA11; cyc();
    bus.ld_rd = 4'd12; bus.ld_data = 32'hA12;
    #1;
    check("full_ld_ready", bus.ld_ready, 0);
    check("full_ld_count", bus.ld_count, 2);
    cyc();
    bus.alu_valid = 0;
    for (int i = 0; i < 8; i++) begin
      bit acc;
      acc = bus.ld_valid && (m_q.size() < DEPTH);
      cyc();
      if (acc) bus.ld_valid = 0;
    end
    #1;
    check("drain_ld_ready", bus.ld_ready, 1);
    check("drain_ld_count", bus.ld_count, 0);
    check("drain_err", bus.err, 0);
    @(negedge clk);

    // Reset with two loads queued
    issue(4'd13); issue(4'd14);
    bus.alu_valid = 1; bus.alu_rd = 4'd2;
    bus.ld_valid = 1; bus.ld_rd = 4'd13; bus.ld_data = 32'hD13; cyc();
    bus.ld_rd = 4'd14; bus.ld_data = 32'hD14; cyc();
    check("pre_rst_count", bus.ld_count, 2);
    idle();
    bus.rs1_addr = 4'd13; bus.rs2_addr = 4'd14;
    rst = 1;
    #1;
    check("mid_rst_w_en", bus.w_en, 0);
    check("mid_rst_count", bus.ld_count, 0);
    check("mid_rst_rs1_busy", bus.rs1_busy, 0);
    check("mid_rst_rs2_busy", bus.rs2_busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bus.alu_valid = 1; bus.alu_rd = 4'd5; bus.alu_data = 32'h1;
    cyc(); idle();
    check("post_rst_w_addr", bus.w_addr, 5);
    check("post_rst_w_data", bus.w_data, 1);
    repeat (4) cyc();

    // Errors
    issue(4'd4); issue(4'd4);
    check("err_double_issue", bus.err, 1);
    do_reset();
    bus.ld_valid = 1; bus.ld_rd = 4'd9; bus.ld_data = 32'h99; cyc(); idle();
    repeat (4) cyc();
    check("err_unpending_load", bus.err, 1);
    do_reset();
    issue(4'd6);
    bus.alu_valid = 1; bus.alu_rd = 4'd6; bus.alu_data = 32'h66; cyc(); idle();
    cyc();
    check("err_waw_alu", bus.err, 1);
    do_reset();

    // Load latency with idle, empty FIFO
    issue(4'd1);
    bus.ld_valid = 1; bus.ld_rd = 4'd1; bus.ld_data = 32'hA5; cyc(); idle();
`ifdef DYT_WB_BYPASS_EN
    check("byp_w_en_n1", bus.w_en, 1);
    check("byp_w_data", bus.w_data, 32'hA5);
    check("byp_ld_count", bus.ld_count, 0);
`else
    check("nobyp_w_en_n1", bus.w_en, 0);
    check("nobyp_ld_count", bus.ld_count, 1);
    cyc();
    check("nobyp_w_en_n2", bus.w_en, 1);
    check("nobyp_w_data", bus.w_data, 32'hA5);
`endif
    repeat (2) cyc();

    // Randomized legal traffic, every output checked against the model each cycle
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      bit acc, iss;
      idle();
      bus.rs1_addr = 4'($urandom_range(0, 15));
      bus.rs2_addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 4) begin
        r = 4'($urandom_range(0, 15));
        bus.alu_valid = 1;
        bus.alu_rd    = m_pend[r] ? 4'd0 : r;
        bus.alu_data  = $urandom;
      end
      iss = 0;
      if ($urandom_range(0, 9) < 3) begin
        r = 4'($urandom_range(1, 15));
        if (!m_pend[r] && !(bus.alu_valid && bus.alu_rd == r)) begin
          bus.iss_valid = 1; bus.iss_rd = r; iss = 1;
        end
      end
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.ld_valid = 1;
        bus.ld_rd    = 4'(out_q[0]);
        bus.ld_data  = $urandom;
      end
      acc = bus.ld_valid && (m_q.size() < DEPTH);
      cyc();
      if (acc) void'(out_q.pop_front());
      if (iss) out_q.push_back(int'(bus.iss_rd));
    end
    idle();
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
